stream_fifo_share_ctrl: RTL and testbench
=========================================

# stream_fifo_share_ctrl

- Shares one downstream stream FIFO between `NUM_REQ` requesters.
- Push side:
  - Round-robin arbitration with a locked grant.
  - Tags each entry with the requester index.
- Per-requester in-flight quota: each requester's entries currently inside the FIFO are counted by watching the FIFO pop handshake. No single requester can fill the shared buffer and starve the others.
- Placement: between N producer streams and the input port of a shared stream FIFO. The FIFO output drives the consumer; this block snoops that output handshake.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, ≥1.
- `DATA_WIDTH`, 32: payload width.
- `QUOTA`, 2: max entries one requester may have in the FIFO, ≥1.
- `IDX_WIDTH`, `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`: derived; do not override.
- `CNT_WIDTH`, `$clog2(QUOTA+1)`: derived; do not override.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous clear of all state. Asserted together with the FIFO's flush.
- `req_valid_i` in `NUM_REQ`: per-requester valid.
- `req_data_i` in `NUM_REQ`×`DATA_WIDTH`: per-requester payload.
- `req_ready_o` out `NUM_REQ`: per-requester ready; one-hot or zero.
- `fifo_data_o` out `IDX_WIDTH+DATA_WIDTH`: `{idx, payload}` to the FIFO input.
- `fifo_valid_o` out 1: push valid.
- `fifo_ready_i` in 1: FIFO input ready (not full).
- `pop_valid_i` in 1: FIFO output valid (snooped).
- `pop_ready_i` in 1: consumer ready (snooped).
- `pop_idx_i` in `IDX_WIDTH`: idx field of the FIFO head entry.
- `inflight_o` out `NUM_REQ`×`CNT_WIDTH`: per-requester in-flight count.
- `idle_o` out 1: all counts zero.

## Operation

- `eligible[i] = req_valid_i[i] & (cnt_q[i] < QUOTA)`.
- **Arbitration:**
  - Grant the first eligible index at or after `rr_q`, searching upward with wrap-around.
  - `fifo_valid_o = |eligible` (or lock held).
  - `fifo_data_o = {grant, req_data_i[grant]}`.
  - `req_ready_o[grant] = fifo_ready_i`; all other bits 0.
- **Lock:**
  - If `fifo_valid_o & ~fifo_ready_i`, set `lock_q` and store the grant in `gnt_q`.
  - While `lock_q` is set, the grant is `gnt_q` regardless of other requests. This keeps valid/data stable per stream protocol.
  - Requesters must keep valid high until handshake. Quota cannot be lost while locked, because counts only decrease.
- **Push handshake** (`fifo_valid_o & fifo_ready_i`):
  - `cnt_q[grant] += 1`.
  - `rr_q <= (grant == NUM_REQ-1) ? 0 : grant+1`.
  - `lock_q <= 0`.
- **Pop handshake** (`pop_valid_i & pop_ready_i`): `cnt_q[pop_idx_i] -= 1`.
- **Push and pop in the same cycle:**
  - Same index: count unchanged.
  - Different indices: both updates apply.
- **Pop with `cnt_q[pop_idx_i] == 0`:** protocol error. The count stays 0 (no wrap) and a simulation assertion fires.
- **Push at quota:** impossible, since an index at `cnt_q[i] == QUOTA` is not eligible. An assertion checks this.
- **`flush_i`:**
  - Next edge: `cnt_q`, `rr_q`, `lock_q`, `gnt_q` go to 0.
  - During the flush cycle, `fifo_valid_o` and all `req_ready_o` are forced to 0, and pop snooping is ignored.
- **`rst_i` high (any time, including mid-transfer):**
  - All state clears asynchronously.
  - `fifo_valid_o`, `req_ready_o` and `inflight_o` read 0; `idle_o` reads 1.
  - `fifo_data_o` is don't-care while valid is 0.
- **`NUM_REQ == 1`:** the arbiter degenerates to a pass-through; idx is always 0 and the quota still applies.

## Timing

- Zero-cycle combinational path from `req_*` and `fifo_ready_i` to `fifo_*` and `req_ready_o`. There is no ready→valid path inside the block except through the lock.
- Counter, pointer and lock updates are visible the cycle after the handshake edge.
- A requester freed by a pop is eligible in the next cycle, not the same cycle.
- Fairness: with all requesters continuously eligible, each is granted exactly once per `NUM_REQ` accepted pushes.

## Test plan

- **Round-robin:** `NUM_REQ=4`, `QUOTA=2`; all 4 requesters valid, `fifo_ready_i=1`, `pop_ready_i=1` with a 1-deep FIFO model → pushed idx sequence is 0,1,2,3,0,1…
- **Quota block:** requester 1 alone valid, no pops → two pushes accepted, then `req_ready_o[1]=0`, `fifo_valid_o=0`, `inflight_o[1]=2`. Pop one idx-1 entry → push resumes the following cycle.
- **Lock:**
  - Requesters 2 and 3 valid, `fifo_ready_i=0` for 5 cycles, `rr_q=3` → grant stays 3 with data stable throughout.
  - Raise ready → idx 3 pushed, `rr_q=0`, then 2 granted.
- **Simultaneous push and pop:**
  - `inflight_o[0]=1`; push idx 0 and pop idx 0 in the same cycle → count stays 1.
  - Push idx 0 while popping idx 2 → counts become 2 and `n-1` respectively.
- **Flush / reset mid-operation:**
  - Counts {2,1,0,2}, lock held; assert `flush_i` → next cycle all counts 0, `idle_o=1`, `rr_q=0`.
  - Repeat with `rst_i` pulsed between edges → outputs 0 immediately.
- **Underflow:** pop idx 3 with `inflight_o[3]=0` → count stays 0 and the assertion fires.

Source files
------------

// File: rtl/stream_fifo_share_ctrl.sv
// Round-robin push arbiter in front of a shared stream FIFO, with per-requester
// in-flight quotas tracked by snooping the FIFO pop handshake.
module stream_fifo_share_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QUOTA      = 2,
    parameter int IDX_WIDTH  = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
    parameter int CNT_WIDTH  = $clog2(QUOTA + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [IDX_WIDTH+DATA_WIDTH-1:0] fifo_data_o,
    output logic                            fifo_valid_o,
    input  logic                            fifo_ready_i,
    input  logic                            pop_valid_i,
    input  logic                            pop_ready_i,
    input  logic [IDX_WIDTH-1:0]            pop_idx_i,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    inflight_o,
    output logic                            idle_o
);

    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0]              r_rr;
    logic [IDX_WIDTH-1:0]              r_gnt;
    logic                              r_lock;

    logic [NUM_REQ-1:0]    w_elig;
    logic [IDX_WIDTH-1:0]  w_rr_gnt;
    logic                  w_found;
    logic [IDX_WIDTH-1:0]  w_gnt;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_REQ-1:0]    w_inc;
    logic [NUM_REQ-1:0]    w_dec;
    logic                  w_underflow;
    logic                  w_overrun;

    // Two passes: first eligible at/after the pointer, else the lowest (which wraps).
    always_comb begin
        w_rr_gnt = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid_i[i] & (r_cnt[i] < CNT_WIDTH'(QUOTA));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i] && IDX_WIDTH'(i) >= r_rr) begin
                w_rr_gnt = IDX_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i]) begin
                w_rr_gnt = IDX_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
    end

    assign w_gnt   = r_lock ? r_gnt : w_rr_gnt;
    assign w_valid = (r_lock | w_found) & ~flush_i & ~rst_i;
    assign w_push  = w_valid & fifo_ready_i;
    assign w_pop   = pop_valid_i & pop_ready_i & ~flush_i;

    always_comb begin
        w_data      = '0;
        req_ready_o = '0;
        w_underflow = 1'b0;
        w_overrun   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == IDX_WIDTH'(i)) begin
                w_data         = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready_o[i] = w_push;
            end
            w_inc[i] = w_push & (w_gnt == IDX_WIDTH'(i));
            // A pop against an empty count saturates at zero instead of wrapping.
            w_dec[i] = w_pop & (pop_idx_i == IDX_WIDTH'(i)) & (r_cnt[i] != '0);
            w_underflow = w_underflow | (w_pop & (pop_idx_i == IDX_WIDTH'(i)) & (r_cnt[i] == '0));
            w_overrun   = w_overrun | (w_inc[i] & (r_cnt[i] == CNT_WIDTH'(QUOTA)));
        end
    end

    assign fifo_valid_o = w_valid;
    assign fifo_data_o  = {w_gnt, w_data};
    assign inflight_o   = r_cnt;
    assign idle_o       = (r_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_rr   <= '0;
            r_gnt  <= '0;
            r_lock <= 1'b0;
        end else if (flush_i) begin
            r_cnt  <= '0;
            r_rr   <= '0;
            r_gnt  <= '0;
            r_lock <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
            end
            if (w_push) begin
                r_rr   <= (w_gnt == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt + IDX_WIDTH'(1);
                r_lock <= 1'b0;
            end else if (w_valid) begin
                // Hold the stalled grant so valid/data stay stable until accepted.
                r_lock <= 1'b1;
                r_gnt  <= w_gnt;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            assert (!w_underflow) else $warning("pop of idx %0d with zero in-flight count", pop_idx_i);
            assert (!w_overrun) else $error("push of a requester already at quota");
        end
    end

endmodule

// File: tb/tb_stream_fifo_share_ctrl.sv
// Directed bench for stream_fifo_share_ctrl: NUM_REQ=4, QUOTA=2, DATA_WIDTH=32.
module tb_stream_fifo_share_ctrl;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int Q  = 2;
    localparam int IW = 2;
    localparam int CW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic [IW+DW-1:0]  fifo_data_o;
    logic              fifo_valid_o;
    logic              fifo_ready_i;
    logic              pop_valid_i;
    logic              pop_ready_i;
    logic [IW-1:0]     pop_idx_i;
    logic [NR*CW-1:0]  inflight_o;
    logic              idle_o;

    int n_chk  = 0;
    int n_pass = 0;

    stream_fifo_share_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUOTA(Q)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .fifo_data_o(fifo_data_o), .fifo_valid_o(fifo_valid_o), .fifo_ready_i(fifo_ready_i),
        .pop_valid_i(pop_valid_i), .pop_ready_i(pop_ready_i), .pop_idx_i(pop_idx_i),
        .inflight_o(inflight_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 4'b1111; fifo_ready_i = 1'b1;
        tick();
        n_chk++; if (fifo_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", fifo_valid_o); else n_pass++;
        n_chk++; if (req_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready_o); else n_pass++;
        n_chk++; if (inflight_o !== 8'h00) $display("FAIL reset_inflight: got %h want 00", inflight_o); else n_pass++;
        n_chk++; if (idle_o !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle_o); else n_pass++;
        req_valid_i = '0;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        req_valid_i = 4'b1111; fifo_ready_i = 1'b1; pop_ready_i = 1'b1; pop_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_chk++;
            if (fifo_valid_o !== 1'b1 || fifo_data_o[IW+DW-1:DW] !== IW'(k % 4) || fifo_data_o[DW-1:0] !== (32'hC0DE_0000 | 32'(k % 4)))
                $display("FAIL rr_push%0d: got v=%b data=%h want v=1 idx=%0d", k, fifo_valid_o, fifo_data_o, k % 4);
            else n_pass++;
            tick();
            pop_valid_i = 1'b1; pop_idx_i = IW'(k % 4);
        end
        req_valid_i = '0;
        tick();
        pop_valid_i = 1'b0;
        #1;
        n_chk++; if (inflight_o !== 8'h00 || idle_o !== 1'b1) $display("FAIL rr_drain: got inflight=%h idle=%b want 00/1", inflight_o, idle_o); else n_pass++;
    endtask

    task automatic test_quota();
        req_valid_i = 4'b0010;
        #1;
        n_chk++; if (req_ready_o !== 4'b0010 || fifo_data_o[IW+DW-1:DW] !== 2'd1) $display("FAIL quota_first: got rdy=%b idx=%0d want 0010/1", req_ready_o, fifo_data_o[IW+DW-1:DW]); else n_pass++;
        tick();
        n_chk++; if (inflight_o !== 8'b00_00_01_00 || fifo_valid_o !== 1'b1) $display("FAIL quota_second: got inflight=%b v=%b want 00000100/1", inflight_o, fifo_valid_o); else n_pass++;
        tick();
        n_chk++; if (inflight_o !== 8'b00_00_10_00) $display("FAIL quota_count: got %b want 00001000", inflight_o); else n_pass++;
        n_chk++; if (fifo_valid_o !== 1'b0 || req_ready_o !== 4'b0000) $display("FAIL quota_block: got v=%b rdy=%b want 0/0000", fifo_valid_o, req_ready_o); else n_pass++;
        pop_valid_i = 1'b1; pop_idx_i = 2'd1;
        #1;
        n_chk++; if (fifo_valid_o !== 1'b0) $display("FAIL quota_same_cycle: got v=%b want 0", fifo_valid_o); else n_pass++;
        tick();
        pop_valid_i = 1'b0;
        #1;
        n_chk++; if (fifo_valid_o !== 1'b1 || req_ready_o !== 4'b0010 || inflight_o !== 8'b00_00_01_00) $display("FAIL quota_resume: got v=%b rdy=%b inflight=%b", fifo_valid_o, req_ready_o, inflight_o); else n_pass++;
        tick();
        req_valid_i = '0; pop_valid_i = 1'b1; pop_idx_i = 2'd1;
        tick(); tick();
        pop_valid_i = 1'b0;
    endtask

    task automatic test_lock();
        // pointer is 2 here; one push of idx 2 moves it to 3
        req_valid_i = 4'b0100;
        tick();
        req_valid_i = 4'b1100; fifo_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++;
            if (fifo_valid_o !== 1'b1 || fifo_data_o !== {2'd3, 32'hC0DE_0003} || req_ready_o !== 4'b0000)
                $display("FAIL lock_hold%0d: got v=%b data=%h rdy=%b want 1/3c0de0003/0000", c, fifo_valid_o, fifo_data_o, req_ready_o);
            else n_pass++;
            tick();
        end
        req_valid_i = 4'b0100;
        #1;
        n_chk++; if (fifo_valid_o !== 1'b1 || fifo_data_o[IW+DW-1:DW] !== 2'd3) $display("FAIL lock_sticky: got v=%b idx=%0d want 1/3", fifo_valid_o, fifo_data_o[IW+DW-1:DW]); else n_pass++;
        req_valid_i = 4'b1100; fifo_ready_i = 1'b1;
        #1;
        n_chk++; if (req_ready_o !== 4'b1000) $display("FAIL lock_release: got %b want 1000", req_ready_o); else n_pass++;
        tick();
        req_valid_i = 4'b0100;
        #1;
        n_chk++; if (req_ready_o !== 4'b0100 || fifo_data_o[IW+DW-1:DW] !== 2'd2) $display("FAIL lock_next: got rdy=%b idx=%0d want 0100/2", req_ready_o, fifo_data_o[IW+DW-1:DW]); else n_pass++;
        tick();
        req_valid_i = '0;
        #1;
        n_chk++; if (inflight_o !== 8'b01_10_00_00) $display("FAIL lock_counts: got %b want 01100000", inflight_o); else n_pass++;
    endtask

    task automatic test_simultaneous();
        req_valid_i = 4'b0001;
        tick();
        pop_valid_i = 1'b1; pop_idx_i = 2'd0;
        #1;
        n_chk++; if (req_ready_o !== 4'b0001) $display("FAIL simul_ready: got %b want 0001", req_ready_o); else n_pass++;
        tick();
        pop_idx_i = 2'd2;
        #1;
        n_chk++; if (inflight_o !== 8'b01_10_00_01) $display("FAIL simul_same: got %b want 01100001", inflight_o); else n_pass++;
        tick();
        pop_valid_i = 1'b0; req_valid_i = '0;
        #1;
        n_chk++; if (inflight_o !== 8'b01_01_00_10) $display("FAIL simul_diff: got %b want 01010010", inflight_o); else n_pass++;
    endtask

    task automatic test_flush();
        req_valid_i = 4'b1010; pop_valid_i = 1'b1; pop_idx_i = 2'd2;
        tick();
        req_valid_i = 4'b1000; pop_valid_i = 1'b0;
        tick();
        req_valid_i = 4'b0100; fifo_ready_i = 1'b0;
        tick();
        n_chk++; if (inflight_o !== 8'b10_00_01_10 || fifo_data_o[IW+DW-1:DW] !== 2'd2) $display("FAIL flush_setup: got inflight=%b idx=%0d want 10000110/2", inflight_o, fifo_data_o[IW+DW-1:DW]); else n_pass++;
        flush_i = 1'b1; fifo_ready_i = 1'b1; pop_valid_i = 1'b1; pop_idx_i = 2'd0;
        #1;
        n_chk++; if (fifo_valid_o !== 1'b0 || req_ready_o !== 4'b0000) $display("FAIL flush_gate: got v=%b rdy=%b want 0/0000", fifo_valid_o, req_ready_o); else n_pass++;
        tick();
        flush_i = 1'b0; pop_valid_i = 1'b0; req_valid_i = 4'b1111;
        #1;
        n_chk++; if (inflight_o !== 8'h00 || idle_o !== 1'b1) $display("FAIL flush_clear: got inflight=%h idle=%b want 00/1", inflight_o, idle_o); else n_pass++;
        n_chk++; if (req_ready_o !== 4'b0001) $display("FAIL flush_rr: got %b want 0001", req_ready_o); else n_pass++;
        req_valid_i = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        req_valid_i = 4'b0011;
        tick(); tick();
        req_valid_i = 4'b0100; fifo_ready_i = 1'b0;
        tick();
        n_chk++; if (inflight_o !== 8'b00_00_01_01 || fifo_valid_o !== 1'b1) $display("FAIL rst_setup: got inflight=%b v=%b want 00000101/1", inflight_o, fifo_valid_o); else n_pass++;
        rst_i = 1'b1;
        #1;
        n_chk++; if (fifo_valid_o !== 1'b0 || req_ready_o !== 4'b0000 || inflight_o !== 8'h00 || idle_o !== 1'b1)
            $display("FAIL rst_async: got v=%b rdy=%b inflight=%h idle=%b want 0/0000/00/1", fifo_valid_o, req_ready_o, inflight_o, idle_o);
        else n_pass++;
        rst_i = 1'b0; req_valid_i = 4'b1111; fifo_ready_i = 1'b1;
        #1;
        n_chk++; if (req_ready_o !== 4'b0001) $display("FAIL rst_rr: got %b want 0001", req_ready_o); else n_pass++;
        req_valid_i = '0;
        tick();
    endtask

    task automatic test_underflow();
        pop_valid_i = 1'b1; pop_idx_i = 2'd3;
        tick();
        pop_valid_i = 1'b0;
        #1;
        n_chk++; if (inflight_o !== 8'h00 || idle_o !== 1'b1) $display("FAIL underflow: got inflight=%h idle=%b want 00/1", inflight_o, idle_o); else n_pass++;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; fifo_ready_i = 1'b1;
        pop_valid_i = 1'b0; pop_ready_i = 1'b1; pop_idx_i = '0;
        for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);
        test_reset();
        test_round_robin();
        test_quota();
        test_lock();
        test_simultaneous();
        test_flush();
        test_reset_midop();
        test_underflow();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
